// File: rtl/sine_period_meter.sv
// Rising mid-scale crossing period meter with hysteresis; `SINE_METER_AMPLITUDE_EN builds the min/max trackers.
// Outputs are registered one cycle after the accepting edge; there is no backpressure, and a sample is accepted every cycle.
module sine_period_meter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  parameter int HYST   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              meas_valid,
  output logic [CNT_W-1:0]  period,
  output logic [DATA_W-1:0] peak_max,
  output logic [DATA_W-1:0] peak_min,
  output logic              locked,
  output logic              timeout
);

  localparam int MID = 1 << (DATA_W - 1);
  localparam logic [DATA_W-1:0] HI_TH = DATA_W'(MID + HYST);
  localparam logic [DATA_W-1:0] LO_TH = DATA_W'(MID - HYST);
  // Last count value that still leaves room for period = cnt + 1 to fit in CNT_W bits.
  localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {S_SYNC, S_ARM, S_HI, S_LO} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic is_hi;
  logic is_lo;
  logic in_period;
  logic take_cross;
  logic take_start;
  logic take_timeout;
  logic take_count;

  assign is_hi     = sample_data > HI_TH;
  assign is_lo     = sample_data < LO_TH;
  assign in_period = (state == S_HI) || (state == S_LO);

  // Exactly one of these fires per accepted sample while a period is being measured.
  assign take_cross   = sample_valid && (state == S_LO) && is_hi;
  assign take_start   = sample_valid && (state == S_ARM) && is_hi;
  assign take_timeout = sample_valid && in_period && !take_cross && (cnt == CNT_LAST);
  assign take_count   = sample_valid && in_period && !take_cross && (cnt != CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_SYNC;
      cnt        <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      locked     <= 1'b0;
    end else begin
      meas_valid <= take_cross;
      timeout    <= take_timeout;
      if (take_cross) begin
        period <= cnt + 1'b1;
        locked <= 1'b1;
        cnt    <= '0;
        state  <= S_HI;
      end else if (take_timeout) begin
        locked <= 1'b0;
        cnt    <= '0;
        state  <= S_SYNC;
      end else if (take_start) begin
        cnt   <= '0;
        state <= S_HI;
      end else if (take_count) begin
        cnt <= cnt + 1'b1;
        if (state == S_HI && is_lo) state <= S_LO;
      end else if (sample_valid && state == S_SYNC && is_lo) begin
        state <= S_ARM;
      end
    end
  end

`ifdef SINE_METER_AMPLITUDE_EN
  logic [DATA_W-1:0] trk_max;
  logic [DATA_W-1:0] trk_min;

  // Trackers include the opening crossing sample but not the closing one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_max  <= '0;
      trk_min  <= '0;
      peak_max <= '0;
      peak_min <= '0;
    end else if (take_start || take_cross) begin
      trk_max <= sample_data;
      trk_min <= sample_data;
      if (take_cross) begin
        peak_max <= trk_max;
        peak_min <= trk_min;
      end
    end else if (take_timeout) begin
      trk_max <= '0;
      trk_min <= '0;
    end else if (take_count) begin
      if (sample_data > trk_max) trk_max <= sample_data;
      if (sample_data < trk_min) trk_min <= sample_data;
    end
  end
`else
  assign peak_max = '0;
  assign peak_min = '0;
`endif

endmodule

// File: tb/tb_sine_period_meter.sv
// Bench for sine_period_meter: two instances (CNT_W 16 and 8) share one stimulus stream against a sample-level model.
module tb_sine_period_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sample_valid;
  logic [7:0] sample_data;

  logic        a_meas, a_locked, a_to;
  logic [15:0] a_period;
  logic [7:0]  a_max, a_min;
  logic        b_meas, b_locked, b_to;
  logic [7:0]  b_period;
  logic [7:0]  b_max, b_min;

  sine_period_meter #(.DATA_W(8), .CNT_W(16), .HYST(8)) dut_a (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
    .meas_valid(a_meas), .period(a_period), .peak_max(a_max), .peak_min(a_min),
    .locked(a_locked), .timeout(a_to));

  sine_period_meter #(.DATA_W(8), .CNT_W(8), .HYST(8)) dut_b (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
    .meas_valid(b_meas), .period(b_period), .peak_max(b_max), .peak_min(b_min),
    .locked(b_locked), .timeout(b_to));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: samples since the last crossing, whether a low was seen since, running extremes.
  int bound [2] = '{65534, 254};
  bit m_armed [2];
  bit m_started [2];
  bit m_low_seen [2];
  int m_n [2];
  int m_hi [2];
  int m_lo [2];
  bit e_meas [2];
  bit e_to [2];
  bit e_locked [2];
  int e_period [2];
  int e_max [2];
  int e_min [2];
  int pulses [2];
  int timeouts [2];

  typedef struct {
    logic [7:0]  d;
    logic        meas;
    logic [15:0] per;
    logic        lck;
    logic [7:0]  pmax;
    logic [7:0]  pmin;
  } vec_t;
  vec_t tbl [32];

  function automatic int pk(input int v);
`ifdef SINE_METER_AMPLITUDE_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_armed[i] = 0; m_started[i] = 0; m_low_seen[i] = 0;
      m_n[i] = 0; m_hi[i] = 0; m_lo[i] = 0;
      e_meas[i] = 0; e_to[i] = 0; e_locked[i] = 0;
      e_period[i] = 0; e_max[i] = 0; e_min[i] = 0;
    end
  endfunction

  function automatic void model_step(input bit v, input int d);
    bit hi;
    bit lo;
    hi = d > 136;
    lo = d < 120;
    for (int i = 0; i < 2; i++) begin
      e_meas[i] = 0;
      e_to[i]   = 0;
      if (v) begin
        if (!m_started[i]) begin
          if (!m_armed[i]) m_armed[i] = lo;
          else if (hi) begin
            m_started[i] = 1; m_n[i] = 0; m_hi[i] = d; m_lo[i] = d; m_low_seen[i] = 0;
          end
        end else if (m_low_seen[i] && hi) begin
          e_meas[i] = 1; e_period[i] = m_n[i] + 1; e_max[i] = m_hi[i]; e_min[i] = m_lo[i];
          e_locked[i] = 1;
          m_n[i] = 0; m_hi[i] = d; m_lo[i] = d; m_low_seen[i] = 0;
        end else if (m_n[i] == bound[i]) begin
          e_to[i] = 1; e_locked[i] = 0;
          m_started[i] = 0; m_armed[i] = 0; m_n[i] = 0;
        end else begin
          m_n[i]++;
          if (d > m_hi[i]) m_hi[i] = d;
          if (d < m_lo[i]) m_lo[i] = d;
          if (lo) m_low_seen[i] = 1;
        end
      end
    end
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_all();
    cmp("a_meas", 32'(a_meas), 32'(e_meas[0]));
    cmp("a_timeout", 32'(a_to), 32'(e_to[0]));
    cmp("a_locked", 32'(a_locked), 32'(e_locked[0]));
    cmp("a_period", 32'(a_period), e_period[0]);
    cmp("a_peak_max", 32'(a_max), pk(e_max[0]));
    cmp("a_peak_min", 32'(a_min), pk(e_min[0]));
    cmp("b_meas", 32'(b_meas), 32'(e_meas[1]));
    cmp("b_timeout", 32'(b_to), 32'(e_to[1]));
    cmp("b_locked", 32'(b_locked), 32'(e_locked[1]));
    cmp("b_period", 32'(b_period), e_period[1]);
    cmp("b_peak_max", 32'(b_max), pk(e_max[1]));
    cmp("b_peak_min", 32'(b_min), pk(e_min[1]));
    pulses[0]   += int'(a_meas);
    pulses[1]   += int'(b_meas);
    timeouts[0] += int'(a_to);
    timeouts[1] += int'(b_to);
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic step(input logic v, input logic [7:0] d);
    sample_valid = v;
    sample_data  = d;
    @(posedge clk);
    model_step(v, int'(d));
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic square(input int n);
    for (int k = 0; k < n; k++) step(1'b1, ((k / 4) % 2) ? 8'd200 : 8'd50);
  endtask

  int last_cyc, npulse, p0, p1, t0, t1, rem;
  bit phase_hi;

  initial begin
    rst = 1'b1;
    sample_valid = 1'b0;
    sample_data = 8'd0;
    model_reset();
    for (int k = 0; k < 32; k++) begin
      tbl[k].d    = ((k / 4) % 2) ? 8'd200 : 8'd50;
      tbl[k].meas = (k >= 12) && ((k - 12) % 8 == 0);
      tbl[k].per  = (k >= 12) ? 16'd8 : 16'd0;
      tbl[k].lck  = (k >= 12);
      tbl[k].pmax = (k >= 12) ? 8'(pk(200)) : 8'd0;
      tbl[k].pmin = (k >= 12) ? 8'(pk(50)) : 8'd0;
    end
    @(negedge clk);
    do_reset();

    // Square lock at full rate.
    for (int k = 0; k < 32; k++) begin
      step(1'b1, tbl[k].d);
      cmp("sq_meas", 32'(a_meas), 32'(tbl[k].meas));
      cmp("sq_period", 32'(a_period), 32'(tbl[k].per));
      cmp("sq_locked", 32'(a_locked), 32'(tbl[k].lck));
      cmp("sq_peak_max", 32'(a_max), 32'(tbl[k].pmax));
      cmp("sq_peak_min", 32'(a_min), 32'(tbl[k].pmin));
      cmp("sq_b_meas", 32'(b_meas), 32'(tbl[k].meas));
    end

    // Valid gaps: every other cycle idle.
    do_reset();
    last_cyc = -1;
    npulse = 0;
    for (int k = 0; k < 32; k++) begin
      step(1'b1, tbl[k].d);
      if (a_meas) begin
        if (last_cyc >= 0) cmp("gap_spacing", 32'(cyc - last_cyc), 32'd16);
        last_cyc = cyc;
        npulse++;
      end
      step(1'b0, 8'd0);
    end
    cmp("gap_pulses", 32'(npulse), 32'd3);
    cmp("gap_period", 32'(a_period), 32'd8);

    // Hysteresis: band-only samples, thresholds themselves included.
    p0 = pulses[0]; p1 = pulses[1]; t1 = timeouts[1];
    for (int k = 0; k < 300; k++)
      step(1'b1, (k < 20) ? ((k % 2) ? 8'd136 : 8'd120) : 8'($urandom_range(121, 135)));
    cmp("hyst_a_no_meas", 32'(pulses[0] - p0), 32'd0);
    cmp("hyst_b_no_meas", 32'(pulses[1] - p1), 32'd0);
    cmp("hyst_a_locked", 32'(a_locked), 32'd1);
    cmp("hyst_b_timeouts", 32'(timeouts[1] - t1), 32'd1);

    // Timeout on the 8-bit counter.
    do_reset();
    square(12);
    step(1'b1, 8'd200);
    cmp("to_lock_meas", 32'(b_meas), 32'd1);
    for (int j = 1; j <= 255; j++) begin
      step(1'b1, 8'd200);
      if (j == 254) cmp("to_early", 32'(b_to), 32'd0);
    end
    cmp("to_pulse", 32'(b_to), 32'd1);
    cmp("to_unlocked", 32'(b_locked), 32'd0);
    cmp("to_period_kept", 32'(b_period), 32'd8);
    cmp("to_a_locked", 32'(a_locked), 32'd1);
    step(1'b1, 8'd200);
    cmp("to_one_cycle", 32'(b_to), 32'd0);

    // Maximum reportable period on the 8-bit counter.
    t1 = timeouts[1];
    step(1'b1, 8'd50);
    step(1'b1, 8'd200);
    for (int j = 0; j < 4; j++) step(1'b1, 8'd50);
    step(1'b1, 8'd200);
    cmp("max_relock", 32'(b_locked), 32'd1);
    for (int j = 0; j < 254; j++) step(1'b1, (j < 100) ? 8'd200 : 8'd50);
    step(1'b1, 8'd200);
    cmp("max_meas", 32'(b_meas), 32'd1);
    cmp("max_period", 32'(b_period), 32'd255);
    cmp("max_no_timeout", 32'(timeouts[1] - t1), 32'd0);

    // Reset while in the low half of a period.
    for (int j = 0; j < 3; j++) step(1'b1, 8'd50);
    do_reset();
    cmp("rst_a_period", 32'(a_period), 32'd0);
    cmp("rst_b_locked", 32'(b_locked), 32'd0);
    p0 = pulses[0];
    square(12);
    cmp("rst_no_early_pulse", 32'(pulses[0] - p0), 32'd0);
    step(1'b1, 8'd200);
    cmp("rst_relock", 32'(a_meas), 32'd1);

    // Randomized square-ish stream with band noise, idle cycles and occasional resets.
    do_reset();
    rem = 0;
    phase_hi = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (rem == 0) begin
        phase_hi = ~phase_hi;
        rem = ($urandom_range(0, 30) == 0) ? int'($urandom_range(200, 300)) : int'($urandom_range(1, 12));
      end
      rem--;
      if ($urandom_range(0, 800) == 0) do_reset();
      step($urandom_range(0, 3) != 0,
           phase_hi ? 8'($urandom_range(125, 255)) : 8'($urandom_range(0, 131)));
    end
    t0 = timeouts[0];
    cmp("rand_a_no_timeout", 32'(t0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
